tick_scheduler: RTL and testbench



---
 rtl/tick_scheduler.sv | 141 ++++++++++++++
 tb/tb_tick_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// Central timebase: a 1 ms strobe from a free-running prescaler, plus the
// game step tick (run/pause/stop gated, adjustable speed), display scan select
// and blink flag derived from it.
//
// state | meaning
// IDLE  | step counter held at 0, no step ticks
// RUN   | step counter advances on ms_tick, step_tick on period expiry
// PAUSE | step counter frozen, no step ticks
module tick_scheduler #(
  parameter int PRESCALE    = 100000,
  parameter int STEP_MAX_MS = 500,
  parameter int STEP_MIN_MS = 100,
  parameter int STEP_DEC_MS = 50,
  parameter int BLINK_MS    = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_req,
  input  logic        pause_req,
  input  logic        stop_req,
  input  logic        speed_up,
  input  logic        speed_reset,
  output logic        ms_tick,
  output logic        step_tick,
  output logic [1:0]  scan_sel,
  output logic        blink,
  output logic [1:0]  state,
  output logic [15:0] step_period
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_nx;
  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic [15:0]   step_cnt;
  logic [15:0]   period_dn;

  // Prescaler wraps every PRESCALE cycles; ms_tick is registered on the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      ms_tick <= 1'b0;
    end else if (presc == PW'(PRESCALE - 1)) begin
      presc   <= '0;
      ms_tick <= 1'b1;
    end else begin
      presc   <= presc + PW'(1);
      ms_tick <= 1'b0;
    end
  end

  // Display scan select and blink flag advance on every ms_tick in all states.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_sel  <= 2'd0;
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (ms_tick) begin
      scan_sel <= scan_sel + 2'd1;
      if (blink_cnt == BW'(BLINK_MS - 1)) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Saturating decrement of the step period, done in 17 bits so it cannot wrap.
  always_comb begin
    period_dn = 16'(STEP_MIN_MS);
    if ({1'b0, step_period} >= (17'(STEP_MIN_MS) + 17'(STEP_DEC_MS)))
      period_dn = step_period - 16'(STEP_DEC_MS);
  end

  // Speed level: reset wins over speed_up; applies in every state.
  always_ff @(posedge clk) begin
    if (rst)
      step_period <= 16'(STEP_MAX_MS);
    else if (speed_reset)
      step_period <= 16'(STEP_MAX_MS);
    else if (speed_up)
      step_period <= period_dn;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_nx;
  end

  // Next-state logic; stop beats pause beats run.
  always_comb begin
    state_nx = state_q;
    if (stop_req) begin
      state_nx = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (run_req) state_nx = RUN;
        RUN:     if (pause_req) state_nx = PAUSE;
        PAUSE:   if (!pause_req && run_req) state_nx = RUN;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Step counter uses the current state for this cycle's ms_tick; >= compare
  // makes a shrunk period fire on the next ms_tick instead of wrapping past it.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt  <= 16'd0;
      step_tick <= 1'b0;
    end else begin
      step_tick <= 1'b0;
      if (state_q == RUN && ms_tick) begin
        if (step_cnt >= step_period - 16'd1) begin
          step_cnt  <= 16'd0;
          step_tick <= 1'b1;
        end else begin
          step_cnt <= step_cnt + 16'd1;
        end
      end
      if (stop_req || state_q == IDLE)
        step_cnt <= 16'd0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with a small timebase. Edge numbers below
// count rising edges since the most recent release of rst; outputs are sampled
// on the falling edge that follows each rising edge.
module tb_tick_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_req, pause_req, stop_req, speed_up, speed_reset;
  logic        ms_tick, step_tick, blink;
  logic [1:0]  scan_sel, state;
  logic [15:0] step_period;

  int n_checks = 0;
  int n_errors = 0;
  int cy = 0;
  int cnt;

  tick_scheduler #(
    .PRESCALE(4), .STEP_MAX_MS(5), .STEP_MIN_MS(2), .STEP_DEC_MS(2), .BLINK_MS(3)
  ) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .pause_req(pause_req),
    .stop_req(stop_req), .speed_up(speed_up), .speed_reset(speed_reset),
    .ms_tick(ms_tick), .step_tick(step_tick), .scan_sel(scan_sel),
    .blink(blink), .state(state), .step_period(step_period)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, cy, got, exp);
    end
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cy++;
    end
  endtask

  task automatic goto_edge(input int t);
    if (t > cy) adv(t - cy);
  endtask

  // advance to edge t, accumulating step_tick pulses seen on the way
  task automatic count_steps(input int t, inout int c);
    while (cy < t) begin
      adv(1);
      c += int'(step_tick);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ms"}, ms_tick, 0);
    check({tag, "_step"}, step_tick, 0);
    check({tag, "_scan"}, scan_sel, 0);
    check({tag, "_blink"}, blink, 0);
    check({tag, "_state"}, state, 0);
    check({tag, "_period"}, step_period, 5);
  endtask

  initial begin
    rst = 1'b1;
    run_req = 1'b0; pause_req = 1'b0; stop_req = 1'b0;
    speed_up = 1'b0; speed_reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    cy = 0;

    // prescaler timing
    goto_edge(3);  check("ms_e3", ms_tick, 0);
    adv(1);        check("ms_e4", ms_tick, 1);
    adv(1);        check("ms_e5", ms_tick, 0);
    goto_edge(8);  check("ms_e8", ms_tick, 1);

    // run: ms_tick at edge 8 is seen while still IDLE, so 5 ticks from 12..28
    run_req = 1'b1; adv(1); run_req = 1'b0;
    check("state_run", state, 1);
    cnt = 0; count_steps(28, cnt);
    check("no_step_before_29", cnt, 0);
    adv(1); check("step_e29", step_tick, 1);
    adv(1); check("step_e30", step_tick, 0);
    goto_edge(48); check("step_e48", step_tick, 0);
    adv(1); check("step_e49", step_tick, 1);
    adv(1); check("step_e50", step_tick, 0);

    // pause after 2 counted ms_ticks (edges 53, 57), resume: 3 more needed
    goto_edge(57);
    pause_req = 1'b1; adv(1); pause_req = 1'b0;
    check("state_pause", state, 2);
    cnt = 0; count_steps(70, cnt);
    run_req = 1'b1; adv(1); run_req = 1'b0;
    check("state_resume", state, 1);
    count_steps(80, cnt);
    check("no_step_paused", cnt, 0);
    adv(1); check("step_e81", step_tick, 1);
    adv(1); check("step_e82", step_tick, 0);

    // speed: 5 -> 3 -> 2 -> 2, then reset wins over speed_up
    speed_up = 1'b1;
    adv(1); check("period_3", step_period, 3);
    adv(1); check("period_2", step_period, 2);
    adv(1); check("period_sat", step_period, 2);
    speed_reset = 1'b1;
    adv(1); speed_up = 1'b0; speed_reset = 1'b0;
    check("period_both", step_period, 5);

    // s=2 after edge 89, shrink to 3 -> fires on ms_tick at 92 (edge 93)
    cnt = 0; count_steps(89, cnt);
    speed_up = 1'b1; adv(1); speed_up = 1'b0;
    check("period_shrink", step_period, 3);
    count_steps(92, cnt);
    check("no_step_83_92", cnt, 0);
    adv(1); check("step_e93", step_tick, 1);
    speed_reset = 1'b1; adv(1); speed_reset = 1'b0;
    check("step_e94", step_tick, 0);
    check("period_reset", step_period, 5);

    // s=3 after edge 105, period drops to 2 -> s already past limit, fires at 109
    cnt = 0; count_steps(105, cnt);
    speed_up = 1'b1; adv(2); speed_up = 1'b0;
    check("period_to_2", step_period, 2);
    count_steps(108, cnt);
    check("no_step_95_108", cnt, 0);
    adv(1); check("step_e109", step_tick, 1);
    adv(1); check("step_e110", step_tick, 0);

    // stop with pause and run together -> IDLE, counter cleared
    goto_edge(113);
    stop_req = 1'b1; pause_req = 1'b1; run_req = 1'b1;
    adv(1);
    stop_req = 1'b0; pause_req = 1'b0; run_req = 1'b0;
    check("state_stop", state, 0);
    cnt = 0; count_steps(125, cnt);
    run_req = 1'b1; adv(1); run_req = 1'b0;
    check("state_rerun", state, 1);
    count_steps(132, cnt);
    check("no_step_after_stop", cnt, 0);
    adv(1); check("step_e133", step_tick, 1);

    // IDLE: 12 ms_ticks of scan_sel/blink
    stop_req = 1'b1; adv(1); stop_req = 1'b0;
    check("state_idle", state, 0);
    while (cy < 182) begin
      adv(1);
      check("ms_period", ms_tick, (cy % 4 == 0) ? 1 : 0);
      if (ms_tick) begin
        check("scan_sel", scan_sel, ((cy - 1) / 4) % 4);
        check("blink", blink, (((cy - 1) / 4) / 3) % 2);
      end
    end

    // reset in the middle of RUN
    run_req = 1'b1; speed_up = 1'b1; adv(1); run_req = 1'b0; speed_up = 1'b0;
    check("pre_rst_state", state, 1);
    check("pre_rst_scan", scan_sel, 1);
    check("pre_rst_blink", blink, 1);
    rst = 1'b1; adv(1);
    check_reset_vals("midrst");
    rst = 1'b0;
    cy = 0;
    goto_edge(3); check("post_rst_ms_e3", ms_tick, 0);
    adv(1);       check("post_rst_ms_e4", ms_tick, 1);
    check("post_rst_state", state, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
